truth_table_sweeper: RTL and testbench
======================================

# truth_table_sweeper

- Sequential stimulus-and-capture stage for the 4-input combinational logic block (inputs a, b, c, d; output S).
- Sweeps the 16 input vectors into the block and samples S after a programmable settle time.
- Assembles the 16-bit truth table and compares it against an expected table.
- Sits directly around the combinational block on the lab board: feeds its inputs and consumes its output.

## Interface
- SETTLE_CYCLES, 2: cycles each vector is held before S is sampled; legal range 1..255.
- EXPECTED, 16'h3320: golden truth table; bit i is the required S for vector i.
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  begin a sweep; accepted only in IDLE.
- abort  input  1  synchronous abort of a running sweep.
- s_in  input  1  S output of the combinational block.
- vec_out  output  4  drives {a,b,c,d}: vec_out[3]=a, [2]=b, [1]=c, [0]=d.
- busy  output  1  high in DRIVE/SAMPLE.
- done  output  1  one-cycle pulse when a sweep completes.
- table_out  output  16  captured truth table, bit i = S for vector i.
- match  output  1  table_out == EXPECTED, valid from done onward.
- mismatch_count  output  5  number of vectors where s_in != EXPECTED[i], 0..16.
- first_fail_idx  output  4  index of first mismatching vector (see Configuration).
- first_fail_valid  output  1  first_fail_idx holds a valid value.

## Operation
- States: IDLE, DRIVE, SAMPLE, DONE.
- IDLE, start=1: clear table_out, mismatch_count, match, first_fail_*; set idx=0, vec_out=0, settle counter=0; go DRIVE.
- DRIVE: hold vec_out=idx and increment the settle counter. After SETTLE_CYCLES cycles in DRIVE, go SAMPLE.
- SAMPLE (one cycle):
  - table_out[idx] <= s_in.
  - If s_in != EXPECTED[idx], mismatch_count += 1.
  - If idx==15, go DONE. Otherwise idx += 1, vec_out <= idx+1, counter=0, go DRIVE.
- DONE (one cycle): done=1, match <= (table_out==EXPECTED); go IDLE.
- Outputs after a sweep:
  - table_out, match, mismatch_count and first_fail_* hold until the next accepted start.
  - vec_out holds 4'hF.
- start while busy or in DONE: ignored.
- abort in DRIVE or SAMPLE:
  - Go IDLE next edge with no done pulse and the SAMPLE capture suppressed.
  - match=0; partial table_out and mismatch_count hold.
  - abort in IDLE/DONE has no effect.
- abort and start in the same IDLE cycle: start wins.
- Widths: idx is 4 bits and never wraps inside a sweep. mismatch_count is 5 bits and saturates by construction at 16.

## Timing
- Reset (rst_n=0, asynchronous, any state including mid-sweep):
  - state=IDLE.
  - vec_out=0, busy=0, done=0, table_out=0, match=0, mismatch_count=0, first_fail_idx=0, first_fail_valid=0.
  - All take effect immediately, no clock needed.
- Define edge k as the edge on which start=1 is sampled in IDLE.
- busy=1 and vec_out=0 after edge k.
- Vector i is sampled at edge k + (i+1)·(SETTLE_CYCLES+1).
- done=1 during the cycle following edge k + 16·(SETTLE_CYCLES+1). With the default, done follows edge k+48.
- busy=0 during the DONE cycle.
- The next start is accepted no earlier than the cycle after done.
- s_in must be stable at least one cycle before its SAMPLE edge; SETTLE_CYCLES ≥ 1 guarantees one full cycle of combinational settle.

## Configuration
- Macro: TRUTH_TABLE_SWEEPER_FIRST_FAIL_EN.
- Defined:
  - On the first SAMPLE with s_in != EXPECTED[idx], latch first_fail_idx=idx and first_fail_valid=1.
  - Later mismatches do not update them.
  - Both are cleared by start and by reset.
- Undefined: first_fail_idx=0 and first_fail_valid=0 constantly; no latch logic is synthesised. Ports remain present.

## Test plan
- Reset value:
  - Stimulus: rst_n=0 for 3 cycles, then release.
  - Response: all outputs 0, busy=0; no activity without start.
- Golden sweep:
  - Stimulus: s_in = ~c & (a | (b & d)) of vec_out, default parameters, one start pulse.
  - Response: done exactly 48 cycles after the start edge; table_out=16'h3320, match=1, mismatch_count=0, first_fail_valid=0.
- Stuck-at-0 output:
  - Stimulus: s_in=0.
  - Response: table_out=0, match=0, mismatch_count=5; with the macro, first_fail_idx=5 and first_fail_valid=1; without it, both 0.
- Ignored start:
  - Stimulus: start pulses at vectors 3 and 9 during a golden sweep.
  - Response: single done at cycle 48, results identical to the golden sweep.
- Abort:
  - Stimulus: abort during vector 7's DRIVE.
  - Response: busy=0 next cycle, no done, table_out bits 0..6 = 7'h20, match=0.
- Mid-sweep reset:
  - Stimulus: rst_n=0 in vector 10, then restart.
  - Response: immediate all-zero outputs; the new sweep reproduces 16'h3320.

Source files
------------

// File: rtl/truth_table_sweeper.sv
// Stimulus-and-capture stage: sweeps 16 vectors into a 4-input block, samples S, checks against EXPECTED.
// Optional first-failure latch enabled by defining TRUTH_TABLE_SWEEPER_FIRST_FAIL_EN.
module truth_table_sweeper #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [15:0] EXPECTED      = 16'h3320
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic        s_in,
  output logic [3:0]  vec_out,
  output logic        busy,
  output logic        done,
  output logic [15:0] table_out,
  output logic        match,
  output logic [4:0]  mismatch_count,
  output logic [3:0]  first_fail_idx,
  output logic        first_fail_valid
);

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

  state_t      state_q;
  logic [3:0]  idx_q;
  logic [7:0]  cnt_q;
  logic [3:0]  vec_q;
  logic        busy_q;
  logic        done_q;
  logic [15:0] table_q;
  logic        match_q;
  logic [4:0]  mcount_q;

  logic        miss;
  logic [15:0] table_d;

  assign miss = (s_in != EXPECTED[idx_q]);

  // Table including the bit being captured this cycle, so match is valid during DONE.
  always_comb begin
    table_d        = table_q;
    table_d[idx_q] = s_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= 4'd0;
      cnt_q    <= 8'd0;
      vec_q    <= 4'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      table_q  <= 16'd0;
      match_q  <= 1'b0;
      mcount_q <= 5'd0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            table_q  <= 16'd0;
            mcount_q <= 5'd0;
            match_q  <= 1'b0;
            idx_q    <= 4'd0;
            vec_q    <= 4'd0;
            cnt_q    <= 8'd0;
            busy_q   <= 1'b1;
            state_q  <= DRIVE;
          end
        end
        DRIVE: begin
          if (abort) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            match_q <= 1'b0;
          end else if (cnt_q == SETTLE_LAST) begin
            state_q <= SAMPLE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        SAMPLE: begin
          if (abort) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            match_q <= 1'b0;
          end else begin
            table_q <= table_d;
            if (miss) mcount_q <= mcount_q + 5'd1;
            if (idx_q == 4'd15) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              match_q <= (table_d == EXPECTED);
            end else begin
              idx_q   <= idx_q + 4'd1;
              vec_q   <= idx_q + 4'd1;
              cnt_q   <= 8'd0;
              state_q <= DRIVE;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef TRUTH_TABLE_SWEEPER_FIRST_FAIL_EN
  logic [3:0] ff_idx_q;
  logic       ff_valid_q;
  logic       sample_ok;

  assign sample_ok = (state_q == SAMPLE) && !abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff_idx_q   <= 4'd0;
      ff_valid_q <= 1'b0;
    end else if (state_q == IDLE && start) begin
      ff_idx_q   <= 4'd0;
      ff_valid_q <= 1'b0;
    end else if (sample_ok && miss && !ff_valid_q) begin
      ff_idx_q   <= idx_q;
      ff_valid_q <= 1'b1;
    end
  end

  assign first_fail_idx   = ff_idx_q;
  assign first_fail_valid = ff_valid_q;
`else
  assign first_fail_idx   = 4'd0;
  assign first_fail_valid = 1'b0;
`endif

  assign vec_out        = vec_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign table_out      = table_q;
  assign match          = match_q;
  assign mismatch_count = mcount_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: table of s_in models plus start/abort/reset corner sequences.
module tb_truth_table_sweeper;

`ifdef TRUTH_TABLE_SWEEPER_FIRST_FAIL_EN
  localparam bit FF_EN = 1'b1;
`else
  localparam bit FF_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        s_in;
  logic [3:0]  vec_out;
  logic        busy, done, match, first_fail_valid;
  logic [15:0] table_out;
  logic [4:0]  mismatch_count;
  logic [3:0]  first_fail_idx;

  int errors = 0;
  int checks = 0;
  int mode   = 0;

  truth_table_sweeper dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .s_in(s_in),
    .vec_out(vec_out), .busy(busy), .done(done), .table_out(table_out),
    .match(match), .mismatch_count(mismatch_count),
    .first_fail_idx(first_fail_idx), .first_fail_valid(first_fail_valid)
  );

  always #5 clk = ~clk;

  // Behavioural stand-in for the combinational block; mode selects a fault.
  function automatic logic model(input int m, input logic [3:0] v);
    logic g;
    g = ~v[1] & (v[3] | (v[2] & v[0]));
    case (m)
      1:       return 1'b0;
      2:       return 1'b1;
      3:       return ~g;
      4:       return g ^ (v == 4'd10);
      default: return g;
    endcase
  endfunction

  always_comb s_in = model(mode, vec_out);

  typedef struct {
    int          m;
    logic [15:0] tbl;
    logic        mt;
    logic [4:0]  mc;
    logic [3:0]  ffi;
    logic        ffv;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_vec"},   32'(vec_out), 0);
    chk({tag, "_busy"},  32'(busy), 0);
    chk({tag, "_done"},  32'(done), 0);
    chk({tag, "_table"}, 32'(table_out), 0);
    chk({tag, "_match"}, 32'(match), 0);
    chk({tag, "_mcnt"},  32'(mismatch_count), 0);
    chk({tag, "_ffi"},   32'(first_fail_idx), 0);
    chk({tag, "_ffv"},   32'(first_fail_valid), 0);
  endtask

  // Start at the next edge (edge k), then run 60 cycles with optional extra start pulses.
  task automatic do_sweep(input int pa, input int pb, output int lat, output int ndone);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_k", 32'(busy), 1);
    chk("vec_after_k", 32'(vec_out), 0);
    lat = 0;
    ndone = 0;
    for (int n = 1; n <= 60; n++) begin
      start = (n == pa) || (n == pb);
      @(posedge clk); #1;
      if (done) begin
        ndone++;
        if (lat == 0) lat = n;
        chk("busy_in_done", 32'(busy), 0);
      end
    end
    start = 1'b0;
  endtask

  task automatic check_results(input string tag, input vec_t v);
    chk({tag, "_table"}, 32'(table_out), 32'(v.tbl));
    chk({tag, "_match"}, 32'(match), 32'(v.mt));
    chk({tag, "_mcnt"},  32'(mismatch_count), 32'(v.mc));
    chk({tag, "_ffi"},   32'(first_fail_idx), FF_EN ? 32'(v.ffi) : 0);
    chk({tag, "_ffv"},   32'(first_fail_valid), FF_EN ? 32'(v.ffv) : 0);
    chk({tag, "_vecF"},  32'(vec_out), 32'hF);
    chk({tag, "_busy"},  32'(busy), 0);
  endtask

  initial begin
    int lat, nd;
    vecs[0] = '{0, 16'h3320, 1'b1, 5'd0,  4'd0,  1'b0};
    vecs[1] = '{1, 16'h0000, 1'b0, 5'd5,  4'd5,  1'b1};
    vecs[2] = '{2, 16'hFFFF, 1'b0, 5'd11, 4'd0,  1'b1};
    vecs[3] = '{3, 16'hCCDF, 1'b0, 5'd16, 4'd0,  1'b1};
    vecs[4] = '{4, 16'h3720, 1'b0, 5'd1,  4'd10, 1'b1};

    // Reset and idle behaviour
    repeat (3) @(posedge clk);
    #1 check_zero("rst");
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1 check_zero("idle");
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_idle_busy", 32'(busy), 0);

    // Table-driven sweeps
    for (int i = 0; i < 5; i++) begin
      mode = vecs[i].m;
      do_sweep(0, 0, lat, nd);
      chk($sformatf("lat_m%0d", i), 32'(lat), 48);
      chk($sformatf("ndone_m%0d", i), 32'(nd), 1);
      check_results($sformatf("res_m%0d", i), vecs[i]);
    end

    // Starts during a golden sweep (vectors 3 and 9) are ignored
    mode = 0;
    do_sweep(10, 28, lat, nd);
    chk("ign_lat", 32'(lat), 48);
    chk("ign_ndone", 32'(nd), 1);
    check_results("ign", vecs[0]);

    // Abort during vector 7's DRIVE
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (21) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    nd = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    chk("abort_ndone", 32'(nd), 0);
    chk("abort_table", 32'(table_out), 32'h0020);
    chk("abort_match", 32'(match), 0);
    chk("abort_mcnt", 32'(mismatch_count), 0);

    // abort and start together in IDLE: start wins
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    chk("startwins_busy", 32'(busy), 1);

    // Mid-sweep asynchronous reset during vector 10, then restart
    repeat (30) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero("midrst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_sweep(0, 0, lat, nd);
    chk("rerun_lat", 32'(lat), 48);
    check_results("rerun", vecs[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
